// File: rtl/pio_in_capture.sv
// pio_in_capture: synchronised, debounced, edge-capturing Avalon-MM input PIO with maskable irq
module pio_in_capture #(
  parameter int WIDTH           = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic CAP_RISE = EDGE_TYPE != 1;
  localparam logic CAP_FALL = EDGE_TYPE != 0;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] sync, deb, upd, ev, irq_mask, edge_cap, clr;
  logic wr;
  assign sync = sync_q[SYNC_STAGES-1];
  assign wr = chipselect & ~write_n;
  assign clr = (wr && address == 2'd3) ? writedata : '0;
  assign irq = |(edge_cap & irq_mask);
  // bits whose debounced level flips on this edge, and which flips count as captured edges
  always_comb begin
    upd = '0;
    ev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = sync[i] != deb[i] && cnt[i] == LAST;
      ev[i] = upd[i] && (sync[i] ? CAP_RISE : CAP_FALL);
    end
  end
  // per-bit synchroniser chains
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  // per-bit persistence counters; a level is accepted once it has held for the full window
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      deb <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      deb <= deb ^ upd;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= (sync[i] == deb[i] || upd[i]) ? '0 : cnt[i] + CW'(1);
    end
  // mask register and sticky edge capture; a new event beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr && address == 2'd1) irq_mask <= writedata;
      edge_cap <= (edge_cap & ~clr) | ev;
    end
  // registered read mux, not qualified by chipselect
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else readdata <= address == 2'd0 ? deb : address == 2'd1 ? irq_mask : address == 2'd3 ? edge_cap : '0;
endmodule

// File: tb/tb_pio_in_capture.sv
// tb_pio_in_capture: directed and random checks of three edge-type variants against a history-window model
module tb_pio_in_capture;
  localparam int W = 18;
  localparam int DC = 4;
  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] address;
  logic chipselect, write_n;
  logic [W-1:0] writedata, in_port;
  logic [W-1:0] rd0, rd1, rd2;
  logic irq0, irq1, irq2;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] m_deb, m_mask, m_flip, m_clr;
  logic [W-1:0] m_ec [3];
  logic [W-1:0] m_rd [3];
  bit m_rst;

  always #5 clk = ~clk;

  pio_in_capture #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));
  pio_in_capture #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1));
  pio_in_capture #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd2), .in_port(in_port), .irq(irq2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    chipselect = 1'b1;
    write_n = 1'b0;
    address = a;
    writedata = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  // Model: a bit's accepted level flips once the synchronised input (input two edges back)
  // has disagreed with it on each of the last DC edges.
  always @(posedge clk) begin
    if (!reset_n) begin
      q = {};
      repeat (DC + 2) q.push_back('0);
      m_deb = '0;
      m_mask = '0;
      for (int t = 0; t < 3; t++) begin
        m_ec[t] = '0;
        m_rd[t] = '0;
      end
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      q.push_back(in_port);
      if (q.size() > DC + 2) void'(q.pop_front());
      for (int i = 0; i < W; i++) begin
        m_flip[i] = 1'b1;
        for (int j = 0; j < DC; j++) if (q[q.size() - 3 - j][i] == m_deb[i]) m_flip[i] = 1'b0;
      end
      for (int t = 0; t < 3; t++)
        m_rd[t] = address == 2'd0 ? m_deb : address == 2'd1 ? m_mask : address == 2'd2 ? '0 : m_ec[t];
      m_clr = (chipselect && !write_n && address == 2'd3) ? writedata : '0;
      m_ec[0] = (m_ec[0] & ~m_clr) | (m_flip & ~m_deb);
      m_ec[1] = (m_ec[1] & ~m_clr) | (m_flip & m_deb);
      m_ec[2] = (m_ec[2] & ~m_clr) | m_flip;
      if (chipselect && !write_n && address == 2'd1) m_mask = writedata;
      m_deb = m_deb ^ m_flip;
    end
  end

  always @(negedge clk)
    if (reset_n && !m_rst) begin
      check("rd0", 32'(rd0), 32'(m_rd[0]));
      check("rd1", 32'(rd1), 32'(m_rd[1]));
      check("rd2", 32'(rd2), 32'(m_rd[2]));
      check("irq0", 32'(irq0), 32'(|(m_ec[0] & m_mask)));
      check("irq1", 32'(irq1), 32'(|(m_ec[1] & m_mask)));
      check("irq2", 32'(irq2), 32'(|(m_ec[2] & m_mask)));
    end

  initial begin
    reset_n = 1'b0;
    in_port = 18'h3FFFF;
    address = 2'd0;
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
    tick(3);
    check("rst_rd", 32'(rd0), 32'h0);
    check("rst_irq", 32'(irq0), 32'h0);
    reset_n = 1'b1;
    tick(8);
    check("rst_data", 32'(rd0), 32'h3FFFF);
    address = 2'd3;
    tick(1);
    check("rst_ec0", 32'(rd0), 32'h3FFFF);
    check("rst_ec1", 32'(rd1), 32'h0);
    check("rst_ec2", 32'(rd2), 32'h3FFFF);
    wr(2'd3, 18'h3FFFF);
    in_port = '0;
    tick(10);
    wr(2'd3, 18'h3FFFF);
    wr(2'd1, 18'h00001);
    in_port[0] = 1'b1;
    tick(3);
    in_port[0] = 1'b0;
    tick(10);
    check("glitch_irq", 32'(irq0), 32'h0);
    address = 2'd3;
    tick(1);
    check("glitch_ec", 32'(rd0[0]), 32'h0);
    in_port[0] = 1'b1;
    tick(5);
    check("deb_edge5", 32'(irq0), 32'h0);
    tick(1);
    check("deb_edge6", 32'(irq0), 32'h1);
    check("deb_edge6_any", 32'(irq2), 32'h1);
    check("deb_rise_t1", 32'(irq1), 32'h0);
    wr(2'd3, 18'h3FFFF);
    wr(2'd1, 18'h00020);
    check("mask_irq_low", 32'(irq0), 32'h0);
    in_port[5] = 1'b1;
    tick(10);
    check("irq_on", 32'(irq0), 32'h1);
    wr(2'd3, 18'h00020);
    check("irq_clr", 32'(irq0), 32'h0);
    in_port[6] = 1'b1;
    tick(10);
    check("masked_irq", 32'(irq0), 32'h0);
    address = 2'd3;
    tick(1);
    check("masked_ec", 32'(rd0[6]), 32'h1);
    wr(2'd3, 18'h3FFFF);
    in_port[5] = 1'b0;
    tick(10);
    wr(2'd3, 18'h3FFFF);
    in_port[5] = 1'b1;
    tick(10);
    check("t0_rise", 32'(rd0[5]), 32'h1);
    check("t1_rise", 32'(rd1[5]), 32'h0);
    check("t2_rise", 32'(rd2[5]), 32'h1);
    wr(2'd3, 18'h00020);
    in_port[5] = 1'b0;
    tick(10);
    check("t0_fall", 32'(rd0[5]), 32'h0);
    check("t1_fall", 32'(rd1[5]), 32'h1);
    check("t2_fall", 32'(rd2[5]), 32'h1);
    wr(2'd3, 18'h3FFFF);
    in_port[2] = 1'b1;
    tick(5);
    wr(2'd3, 18'h00004);
    tick(1);
    check("set_wins", 32'(rd0[2]), 32'h1);
    wr(2'd3, 18'h00004);
    tick(1);
    check("clr_only", 32'(rd0[2]), 32'h0);
    address = 2'd0;
    tick(1);
    check("data_pre", 32'(rd0), 32'h00045);
    wr(2'd0, 18'h2AAAA);
    tick(1);
    check("data_ro", 32'(rd0), 32'h00045);
    wr(2'd2, 18'h2AAAA);
    tick(1);
    check("rsv_zero", 32'(rd0), 32'h0);
    wr(2'd1, 18'h15555);
    check("mask_old", 32'(rd0), 32'h00020);
    tick(1);
    check("mask_rb", 32'(rd0), 32'h15555);
    in_port = 18'h3FFFF;
    tick(3);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(8);
    address = 2'd0;
    tick(1);
    check("post_rst_data", 32'(rd0), 32'h3FFFF);
    address = 2'd3;
    tick(1);
    check("post_rst_ec", 32'(rd0), 32'h3FFFF);
    check("post_rst_irq", 32'(irq0), 32'h0);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = $urandom_range(0, W - 1);
        in_port[b] = ~in_port[b];
      end
      if (n == 300) begin
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 6) == 0) wr(2'($urandom_range(0, 3)), W'($urandom));
      else begin
        address = 2'($urandom_range(0, 3));
        tick(1);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
